// File: rtl/memory_controller.sv
// Memory access sequencer between the control unit and the 16-bit data memory.
// One transaction per request: lane enables, write-data steering, read alignment,
// PSW redirection and fault reporting for bad accesses.
module memory_controller #(
    parameter int unsigned WORD        = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_i,
    input  logic            write_i,
    input  logic [WORD-1:0] addr_i,
    input  logic [WORD-1:0] wdata_i,
    input  logic [1:0]      datSel_i,
    input  logic            badMem_i,
    input  logic            pswAddr_i,
    input  logic [WORD-1:0] psw_i,
    output logic [WORD-1:0] rdata_o,
    output logic            ack_o,
    output logic            fault_o,
    output logic            busy_o,
    output logic            psw_we_o,
    output logic [WORD-1:0] psw_wdata_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [1:0]      mem_be_o,
    output logic [WORD-1:0] mem_addr_o,
    output logic [WORD-1:0] mem_wdata_o,
    input  logic [WORD-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StPsw,
        StFault,
        StDone
    } state_e;

    localparam logic [1:0] SelBad  = 2'd0;
    localparam logic [1:0] SelLb   = 2'd1;
    localparam logic [1:0] SelHb   = 2'd2;
    localparam logic [1:0] SelWord = 2'd3;
    localparam logic [3:0] LastCnt = 4'(WAIT_STATES);

    state_e          r_state;
    state_e          w_state_next;
    logic [3:0]      r_cnt;
    logic [WORD-1:0] r_addr;
    logic [WORD-1:0] r_wdata;
    logic            r_write;
    logic [1:0]      r_sel;
    logic            r_fault;
    logic [WORD-1:0] r_rdata;

    // Byte reads are zero-extended; sign extension is the control unit's job.
    function automatic logic [WORD-1:0] align_rd(input logic [WORD-1:0] d,
                                                 input logic [1:0]      sel);
        case (sel)
            SelLb:   align_rd = {{(WORD-8){1'b0}}, d[7:0]};
            SelHb:   align_rd = {{(WORD-8){1'b0}}, d[15:8]};
            default: align_rd = d;
        endcase
    endfunction

    // State register, request latch, access counter, read capture and fault flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_sel   <= SelBad;
            r_fault <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    r_cnt <= 4'd0;
                    if (req_i) begin
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_write <= write_i;
                        r_sel   <= datSel_i;
                    end
                end
                StAccess: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LastCnt && !r_write) begin
                        r_rdata <= align_rd(mem_rdata_i, r_sel);
                    end
                end
                StPsw: begin
                    if (!r_write) begin
                        r_rdata <= align_rd(psw_i, r_sel);
                    end
                end
                StFault: begin
                    r_rdata <= '0;
                    r_fault <= 1'b1;
                end
                StDone: begin
                    // Flag is seen by fault_o during DONE, then cleared for IDLE.
                    r_fault <= 1'b0;
                    r_cnt   <= 4'd0;
                end
                default: r_cnt <= 4'd0;
            endcase
        end
    end

    // Next-state decode and per-state output strobes.
    always_comb begin
        w_state_next = r_state;
        ack_o        = 1'b0;
        busy_o       = 1'b1;
        mem_en_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 2'b00;
        psw_we_o     = 1'b0;
        psw_wdata_o  = '0;
        case (r_state)
            StIdle: begin
                busy_o = 1'b0;
                if (req_i) begin
                    // Fault wins over PSW so a bad PSW access never writes the PSW.
                    if (badMem_i || datSel_i == SelBad) begin
                        w_state_next = StFault;
                    end else if (pswAddr_i) begin
                        w_state_next = StPsw;
                    end else begin
                        w_state_next = StAccess;
                    end
                end
            end
            StAccess: begin
                mem_en_o = 1'b1;
                mem_we_o = r_write;
                case (r_sel)
                    SelLb:   mem_be_o = 2'b01;
                    SelHb:   mem_be_o = 2'b10;
                    SelWord: mem_be_o = 2'b11;
                    default: mem_be_o = 2'b00;
                endcase
                if (r_cnt == LastCnt) begin
                    w_state_next = StDone;
                end
            end
            StPsw: begin
                psw_we_o = r_write;
                if (r_write) begin
                    case (r_sel)
                        SelLb:   psw_wdata_o = {psw_i[15:8], r_wdata[7:0]};
                        SelHb:   psw_wdata_o = {r_wdata[7:0], psw_i[7:0]};
                        default: psw_wdata_o = r_wdata;
                    endcase
                end
                w_state_next = StDone;
            end
            StFault: begin
                w_state_next = StDone;
            end
            StDone: begin
                ack_o        = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign fault_o     = ack_o & r_fault;
    assign rdata_o     = r_rdata;
    assign mem_addr_o  = {r_addr[WORD-1:1], 1'b0};
    // Byte writes replicate the byte on both lanes; mem_be_o picks the live one.
    assign mem_wdata_o = (r_sel == SelWord) ? r_wdata : {r_wdata[7:0], r_wdata[7:0]};

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller. Three instances share stimulus:
// index 0 has WAIT_STATES=1, index 1 has 3, index 2 has 0.
module tb_memory_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  sel;
    logic        bad;
    logic        psw_hit;
    logic [15:0] psw;
    logic [15:0] mem_rdata;

    logic [15:0] rdata     [3];
    logic [15:0] psw_wdata [3];
    logic [15:0] mem_addr  [3];
    logic [15:0] mem_wdata [3];
    logic [1:0]  mem_be    [3];
    logic [2:0]  ack, fault, busy, psw_we, mem_en, mem_we;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memory_controller #(.WORD(16), .WAIT_STATES(1)) u_ws1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
        .wdata_i(wdata), .datSel_i(sel), .badMem_i(bad), .pswAddr_i(psw_hit), .psw_i(psw),
        .rdata_o(rdata[0]), .ack_o(ack[0]), .fault_o(fault[0]), .busy_o(busy[0]),
        .psw_we_o(psw_we[0]), .psw_wdata_o(psw_wdata[0]), .mem_en_o(mem_en[0]),
        .mem_we_o(mem_we[0]), .mem_be_o(mem_be[0]), .mem_addr_o(mem_addr[0]),
        .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata)
    );

    memory_controller #(.WORD(16), .WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
        .wdata_i(wdata), .datSel_i(sel), .badMem_i(bad), .pswAddr_i(psw_hit), .psw_i(psw),
        .rdata_o(rdata[1]), .ack_o(ack[1]), .fault_o(fault[1]), .busy_o(busy[1]),
        .psw_we_o(psw_we[1]), .psw_wdata_o(psw_wdata[1]), .mem_en_o(mem_en[1]),
        .mem_we_o(mem_we[1]), .mem_be_o(mem_be[1]), .mem_addr_o(mem_addr[1]),
        .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata)
    );

    memory_controller #(.WORD(16), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
        .wdata_i(wdata), .datSel_i(sel), .badMem_i(bad), .pswAddr_i(psw_hit), .psw_i(psw),
        .rdata_o(rdata[2]), .ack_o(ack[2]), .fault_o(fault[2]), .busy_o(busy[2]),
        .psw_we_o(psw_we[2]), .psw_wdata_o(psw_wdata[2]), .mem_en_o(mem_en[2]),
        .mem_we_o(mem_we[2]), .mem_be_o(mem_be[2]), .mem_addr_o(mem_addr[2]),
        .mem_wdata_o(mem_wdata[2]), .mem_rdata_i(mem_rdata)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current (IDLE) cycle 0.
    task automatic start(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] s, input logic b, input logic p);
        wr = w; addr = a; wdata = d; sel = s; bad = b; psw_hit = p; req = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_chk++; if ({ack[i], fault[i], busy[i], psw_we[i], mem_en[i], mem_we[i]} !== 6'b0)
                begin n_err++; $display("FAIL reset strobes[%0d]: got %b want 0", i,
                {ack[i], fault[i], busy[i], psw_we[i], mem_en[i], mem_we[i]}); end
            n_chk++; if ({rdata[i], psw_wdata[i], mem_addr[i], mem_wdata[i], mem_be[i]} !== 66'b0)
                begin n_err++; $display("FAIL reset data[%0d]: rd %h pw %h ad %h wd %h be %b",
                i, rdata[i], psw_wdata[i], mem_addr[i], mem_wdata[i], mem_be[i]); end
        end
    endtask

    task automatic test_word_read();
        do_reset();
        mem_rdata = 16'hBEEF;
        start(1'b0, 16'h0100, 16'h0000, 2'd3, 1'b0, 1'b0);
        n_chk++; if (busy[0] !== 1'b0) begin n_err++;
            $display("FAIL wr c0 busy: got %b want 0", busy[0]); end
        tick(); req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            n_chk++; if ({mem_en[0], mem_we[0], mem_be[0]} !== 4'b1011) begin n_err++;
                $display("FAIL wr c%0d en/we/be: got %b want 1011", c,
                {mem_en[0], mem_we[0], mem_be[0]}); end
            n_chk++; if (mem_addr[0] !== 16'h0100) begin n_err++;
                $display("FAIL wr c%0d addr: got %h want 0100", c, mem_addr[0]); end
            n_chk++; if (ack[0] !== 1'b0) begin n_err++;
                $display("FAIL wr c%0d early ack: got %b want 0", c, ack[0]); end
            tick();
        end
        n_chk++; if ({ack[0], fault[0], mem_en[0]} !== 3'b100) begin n_err++;
            $display("FAIL wr c3 ack/fault/en: got %b want 100", {ack[0], fault[0], mem_en[0]}); end
        n_chk++; if (rdata[0] !== 16'hBEEF) begin n_err++;
            $display("FAIL wr c3 rdata: got %h want beef", rdata[0]); end
        tick();
        n_chk++; if ({ack[0], busy[0], mem_en[0], mem_be[0]} !== 5'b0) begin n_err++;
            $display("FAIL wr c4 idle: got %b want 0", {ack[0], busy[0], mem_en[0], mem_be[0]}); end
        n_chk++; if (mem_addr[0] !== 16'h0100) begin n_err++;
            $display("FAIL wr c4 addr hold: got %h want 0100", mem_addr[0]); end
    endtask

    task automatic test_byte_access();
        do_reset();
        start(1'b1, 16'h0201, 16'h12AB, 2'd2, 1'b0, 1'b0);
        tick(); req = 1'b0;
        n_chk++; if ({mem_en[0], mem_we[0], mem_be[0]} !== 4'b1110) begin n_err++;
            $display("FAIL hbw en/we/be: got %b want 1110", {mem_en[0], mem_we[0], mem_be[0]}); end
        n_chk++; if (mem_wdata[0] !== 16'hABAB) begin n_err++;
            $display("FAIL hbw wdata: got %h want abab", mem_wdata[0]); end
        n_chk++; if (mem_addr[0] !== 16'h0200) begin n_err++;
            $display("FAIL hbw addr: got %h want 0200", mem_addr[0]); end
        tick(); tick();
        n_chk++; if (ack[0] !== 1'b1) begin n_err++;
            $display("FAIL hbw ack: got %b want 1", ack[0]); end
        tick();
        mem_rdata = 16'h5A3C;
        start(1'b0, 16'h0200, 16'h0000, 2'd1, 1'b0, 1'b0);
        tick(); req = 1'b0;
        n_chk++; if ({mem_en[0], mem_we[0], mem_be[0]} !== 4'b1001) begin n_err++;
            $display("FAIL lbr en/we/be: got %b want 1001", {mem_en[0], mem_we[0], mem_be[0]}); end
        tick(); tick();
        n_chk++; if ({ack[0], rdata[0]} !== {1'b1, 16'h003C}) begin n_err++;
            $display("FAIL lbr ack/rdata: got %b/%h want 1/003c", ack[0], rdata[0]); end
        tick();
        start(1'b0, 16'h0201, 16'h0000, 2'd2, 1'b0, 1'b0);
        tick(); req = 1'b0; tick(); tick();
        n_chk++; if ({ack[0], rdata[0]} !== {1'b1, 16'h005A}) begin n_err++;
            $display("FAIL hbr ack/rdata: got %b/%h want 1/005a", ack[0], rdata[0]); end
        tick();
    endtask

    task automatic test_fault();
        // rdata currently holds 0x005A from the previous read.
        start(1'b1, 16'h0101, 16'h4444, 2'd3, 1'b1, 1'b0);
        tick(); req = 1'b0;
        n_chk++; if ({busy[0], mem_en[0], mem_we[0], psw_we[0], ack[0]} !== 5'b10000) begin
            n_err++; $display("FAIL mis c1: got %b want 10000",
            {busy[0], mem_en[0], mem_we[0], psw_we[0], ack[0]}); end
        tick();
        n_chk++; if ({ack[0], fault[0], mem_en[0]} !== 3'b110) begin n_err++;
            $display("FAIL mis c2 ack/fault/en: got %b want 110", {ack[0], fault[0], mem_en[0]}); end
        n_chk++; if (rdata[0] !== 16'h0000) begin n_err++;
            $display("FAIL mis c2 rdata: got %h want 0000", rdata[0]); end
        tick();
        // BAD lane select on the PSW address must fault, not touch the PSW.
        start(1'b1, 16'hFFFF, 16'h9999, 2'd0, 1'b0, 1'b1);
        tick(); req = 1'b0;
        n_chk++; if ({psw_we[0], mem_en[0]} !== 2'b00) begin n_err++;
            $display("FAIL bad c1 psw_we/en: got %b want 00", {psw_we[0], mem_en[0]}); end
        tick();
        n_chk++; if ({ack[0], fault[0]} !== 2'b11) begin n_err++;
            $display("FAIL bad c2 ack/fault: got %b want 11", {ack[0], fault[0]}); end
        tick();
    endtask

    task automatic test_psw();
        psw = 16'h1200;
        start(1'b1, 16'hFFFC, 16'h0077, 2'd1, 1'b0, 1'b1);
        tick(); req = 1'b0;
        n_chk++; if ({psw_we[0], mem_en[0], ack[0]} !== 3'b100) begin n_err++;
            $display("FAIL pswlb c1 we/en/ack: got %b want 100", {psw_we[0], mem_en[0], ack[0]}); end
        n_chk++; if (psw_wdata[0] !== 16'h1277) begin n_err++;
            $display("FAIL pswlb c1 wdata: got %h want 1277", psw_wdata[0]); end
        tick();
        n_chk++; if ({ack[0], fault[0], psw_we[0]} !== 3'b100) begin n_err++;
            $display("FAIL pswlb c2 ack/fault/we: got %b want 100", {ack[0], fault[0], psw_we[0]}); end
        tick();
        start(1'b1, 16'hFFFD, 16'h0034, 2'd2, 1'b0, 1'b1);
        tick(); req = 1'b0;
        n_chk++; if ({psw_we[0], psw_wdata[0]} !== {1'b1, 16'h3400}) begin n_err++;
            $display("FAIL pswhb we/wdata: got %b/%h want 1/3400", psw_we[0], psw_wdata[0]); end
        tick(); tick();
        start(1'b0, 16'hFFFC, 16'h0000, 2'd3, 1'b0, 1'b1);
        tick(); req = 1'b0;
        n_chk++; if ({psw_we[0], mem_en[0]} !== 2'b00) begin n_err++;
            $display("FAIL pswrd c1 we/en: got %b want 00", {psw_we[0], mem_en[0]}); end
        tick();
        n_chk++; if ({ack[0], rdata[0]} !== {1'b1, 16'h1200}) begin n_err++;
            $display("FAIL pswrd ack/rdata: got %b/%h want 1/1200", ack[0], rdata[0]); end
        tick();
        start(1'b0, 16'hFFFD, 16'h0000, 2'd2, 1'b0, 1'b1);
        tick(); req = 1'b0; tick();
        n_chk++; if ({ack[0], rdata[0]} !== {1'b1, 16'h0012}) begin n_err++;
            $display("FAIL pswhbrd ack/rdata: got %b/%h want 1/0012", ack[0], rdata[0]); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        int acks;
        do_reset();
        mem_rdata = 16'hC0DE;
        start(1'b0, 16'h0300, 16'h0000, 2'd3, 1'b0, 1'b0);
        tick(); req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_chk++; if ({mem_en[1], ack[1]} !== 2'b10) begin n_err++;
                $display("FAIL ws3 c%0d en/ack: got %b want 10", c, {mem_en[1], ack[1]}); end
            tick();
        end
        n_chk++; if ({ack[1], rdata[1]} !== {1'b1, 16'hC0DE}) begin n_err++;
            $display("FAIL ws3 c5 ack/rdata: got %b/%h want 1/c0de", ack[1], rdata[1]); end
        tick();
        start(1'b1, 16'h0302, 16'h5555, 2'd3, 1'b0, 1'b0);
        tick(); req = 1'b0;
        tick();
        n_chk++; if ({mem_en[1], mem_we[1]} !== 2'b11) begin n_err++;
            $display("FAIL rst c2 en/we: got %b want 11", {mem_en[1], mem_we[1]}); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_chk++; if ({ack[1], fault[1], busy[1], psw_we[1], mem_en[1], mem_we[1]} !== 6'b0)
            begin n_err++; $display("FAIL rst mid strobes: got %b want 0",
            {ack[1], fault[1], busy[1], psw_we[1], mem_en[1], mem_we[1]}); end
        n_chk++; if ({rdata[1], psw_wdata[1], mem_addr[1], mem_wdata[1], mem_be[1]} !== 66'b0)
            begin n_err++; $display("FAIL rst mid data: rd %h pw %h ad %h wd %h be %b",
            rdata[1], psw_wdata[1], mem_addr[1], mem_wdata[1], mem_be[1]); end
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            if (ack[1] === 1'b1) acks++;
            tick();
        end
        n_chk++; if (acks !== 0) begin n_err++;
            $display("FAIL rst no-ack: got %0d acks want 0", acks); end
        mem_rdata = 16'h7E57;
        start(1'b0, 16'h0304, 16'h0000, 2'd3, 1'b0, 1'b0);
        tick(); req = 1'b0;
        tick(); tick(); tick(); tick();
        n_chk++; if ({ack[1], fault[1], rdata[1]} !== {2'b10, 16'h7E57}) begin n_err++;
            $display("FAIL rst after ack/fault/rdata: got %b/%b/%h want 1/0/7e57",
            ack[1], fault[1], rdata[1]); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_rdata = 16'h1111;
        start(1'b0, 16'h0400, 16'h0000, 2'd3, 1'b0, 1'b0);
        for (int c = 0; c <= 6; c++) begin
            n_chk++; if (ack[2] !== (c == 2 || c == 5)) begin n_err++;
                $display("FAIL b2b c%0d ack: got %b want %b", c, ack[2], (c == 2 || c == 5)); end
            n_chk++; if (busy[2] !== !(c == 0 || c == 3 || c == 6)) begin n_err++;
                $display("FAIL b2b c%0d busy: got %b want %b", c, busy[2],
                !(c == 0 || c == 3 || c == 6)); end
            if (c == 1) begin
                n_chk++; if ({mem_en[2], mem_be[2]} !== 3'b111) begin n_err++;
                    $display("FAIL b2b c1 en/be: got %b want 111", {mem_en[2], mem_be[2]}); end
            end
            if (c == 2) begin
                n_chk++; if (rdata[2] !== 16'h1111) begin n_err++;
                    $display("FAIL b2b c2 rdata: got %h want 1111", rdata[2]); end
            end
            if (c == 5) begin
                n_chk++; if (rdata[2] !== 16'h2222) begin n_err++;
                    $display("FAIL b2b c5 rdata: got %h want 2222", rdata[2]); end
            end
            if (c == 3) mem_rdata = 16'h2222;
            tick();
            if (c == 3) req = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sel = 2'd0;
        bad = 1'b0; psw_hit = 1'b0; psw = '0; mem_rdata = '0;
        test_reset();
        test_word_read();
        test_byte_access();
        test_fault();
        test_psw();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/memory_controller.md
# memory_controller

Multi-cycle memory access sequencer between the X-Makina control unit and the unified 16-bit data memory. It sits directly downstream of `address_decoder` and consumes that block's byte-lane select, misalignment and PSW-address flags. It runs one memory transaction per request: byte-lane enables, write-data steering and read-data alignment. Accesses to the PSW address go to the PSW register instead of memory, and bad accesses are reported as faults without touching memory.

## Interface

Reset is synchronous and active-low, on `rst_n_i`, in the single `clk_i` domain.

**Parameters**
- `WORD` (default 16): data and address width.
- `WAIT_STATES` (default 1): extra memory cycles per access; range 0..15.

**Ports**
- `clk_i` in, 1: clock.
- `rst_n_i` in, 1: synchronous active-low reset.
- `req_i` in, 1: access request from the control unit; sampled only in IDLE.
- `write_i` in, 1: 1 = write, 0 = read.
- `addr_i` in, WORD: byte address.
- `wdata_i` in, WORD: write data; a byte is taken from `[7:0]`.
- `datSel_i` in, 2: lane select from `address_decoder`. 0 = BAD, 1 = LB, 2 = HB, 3 = WORD.
- `badMem_i` in, 1: misaligned word access.
- `pswAddr_i` in, 1: address hits the PSW word.
- `psw_i` in, WORD: current PSW value.
- `rdata_o` out, WORD: aligned read data; valid while `ack_o` is high.
- `ack_o` out, 1: one-cycle completion pulse.
- `fault_o` out, 1: completion was a bad access; valid only with `ack_o`.
- `busy_o` out, 1: high in every state except IDLE.
- `psw_we_o` out, 1: one-cycle PSW write strobe.
- `psw_wdata_o` out, WORD: merged PSW write value.
- `mem_en_o` out, 1: memory enable.
- `mem_we_o` out, 1: memory write enable.
- `mem_be_o` out, 2: byte enables; bit 0 = low byte, bit 1 = high byte.
- `mem_addr_o` out, WORD: word address, `{addr[WORD-1:1],1'b0}`.
- `mem_wdata_o` out, WORD: steered write data.
- `mem_rdata_i` in, WORD: memory read data; valid on the last ACCESS cycle.

## Operation

**IDLE**
- When `req_i` is high, latch `addr_i`, `write_i`, `wdata_i` and `datSel_i`.
- Next state:
  - FAULT if `badMem_i` is high or `datSel_i` is BAD.
  - Otherwise PSW if `pswAddr_i` is high.
  - Otherwise ACCESS.
- FAULT takes priority over PSW.

**ACCESS**
- Drive `mem_en_o`=1 and `mem_we_o`=latched write for exactly `WAIT_STATES+1` cycles.
- A 4-bit counter starts at 0 and increments each ACCESS cycle.
- On the clock edge where counter == `WAIT_STATES`: capture read data into `rdata_o` if reading, then go to DONE.

**PSW** (one cycle)
- Read: `rdata_o` is loaded from `psw_i`, aligned as for memory.
- Write: `psw_we_o` pulses for this cycle.
  - WORD: `psw_wdata_o = wdata`.
  - LB: `{psw_i[15:8], wdata[7:0]}`.
  - HB: `{wdata[7:0], psw_i[7:0]}`.
- Then go to DONE.

**FAULT** (one cycle)
- No memory or PSW activity.
- `rdata_o` is set to 0 and a fault flag is set.
- Then go to DONE.

**DONE** (one cycle)
- `ack_o`=1; `fault_o` = fault flag.
- Then go to IDLE. The flag clears on entry to IDLE.

**Lane rules**
- WORD: `mem_be_o`=11, `mem_wdata_o`=wdata, `rdata_o`=mem_rdata.
- LB: `mem_be_o`=01, `mem_wdata_o={wdata[7:0],wdata[7:0]}`, `rdata_o={8'h00,mem_rdata[7:0]}`.
- HB: `mem_be_o`=10, `mem_wdata_o={wdata[7:0],wdata[7:0]}`, `rdata_o={8'h00,mem_rdata[15:8]}`.
- Read data is zero-extended; sign extension belongs to the control unit.

**Idle outputs**
- Outside ACCESS: `mem_en_o`, `mem_we_o` and `mem_be_o` are 0.
- `mem_addr_o` and `mem_wdata_o` hold the latched values.

**Request handling**
- `req_i` is ignored outside IDLE.
- `req_i` still high in the cycle after DONE (IDLE) starts a new transaction.

## Timing

- Cycle 0 is IDLE with `req_i` sampled.
- Memory access: ACCESS occupies cycles 1..`WAIT_STATES`+1; `ack_o` is high in cycle `WAIT_STATES`+2.
- PSW and FAULT accesses: `ack_o` is high in cycle 2.
- Back-to-back throughput is one request per `WAIT_STATES`+3 cycles (memory), or 3 cycles (PSW/fault).

**Reset** (`rst_n_i` low at a rising edge)
- State goes to IDLE and the counter to 0.
- All outputs go to 0: `rdata_o`, `ack_o`, `fault_o`, `busy_o`, `psw_we_o`, `psw_wdata_o`, `mem_*_o`.
- Reset mid-ACCESS drops `mem_en_o` and `mem_we_o` at that edge; no `ack_o` is produced for the aborted transaction.

**Boundary conditions**
- `WAIT_STATES`=0 gives a single ACCESS cycle.
- Address 0xFFFF (exception-return value) with WORD select is BAD and goes to FAULT.
- Address 0xFFFD with a byte access to the PSW selects HB of the PSW.

## Test plan

1. **Word read, `WAIT_STATES`=1.** Read, addr 0x0100, `datSel`=3, `mem_rdata`=0xBEEF.
   - `mem_en_o` high cycles 1–2, `mem_be_o`=11, `mem_addr_o`=0x0100.
   - `ack_o` at cycle 3 with `rdata_o`=0xBEEF, `fault_o`=0.
2. **Byte writes.**
   - Write 0x0201, `datSel`=HB, wdata 0x12AB: `mem_be_o`=10, `mem_wdata_o`=0xABAB, `mem_we_o`=1, `mem_addr_o`=0x0200.
   - Read 0x0200, LB, with memory 0x5A3C: `rdata_o`=0x003C.
3. **Misaligned word write.** addr 0x0101, `badMem`=1: `mem_en_o` never asserts; `ack_o` and `fault_o` high at cycle 2, `rdata_o`=0.
4. **PSW access.**
   - LB write to 0xFFFC, wdata 0x0077, `psw_i`=0x1200: `psw_we_o` pulse at cycle 1, `psw_wdata_o`=0x1277, no memory enable, `ack_o` at cycle 2.
   - Word read of 0xFFFC: `rdata_o`=`psw_i`.
5. **Reset mid-access.** `WAIT_STATES`=3, reset asserted in cycle 2 of ACCESS:
   - Every output is 0 after the edge and no `ack_o` appears.
   - A new request afterwards completes normally.
6. **Back-to-back requests.** `req_i` held high for two word reads, `WAIT_STATES`=0:
   - `ack_o` pulses at cycles 2 and 5.
   - `busy_o` is low only at cycles 0 and 3.
